// File: rtl/nv_nvdla_sdp_arb_pkg.sv
// Shared constants for the SDP read-request arbiter: requester ids and default widths.
package nv_nvdla_sdp_arb_pkg;

    localparam int unsigned SDP_ARB_MRDMA   = 0;
    localparam int unsigned SDP_ARB_BRDMA   = 1;
    localparam int unsigned SDP_ARB_NRDMA   = 2;
    localparam int unsigned SDP_ARB_ERDMA   = 3;

    localparam int unsigned SDP_ARB_NUM_REQ = 4;
    localparam int unsigned SDP_ARB_ID_W    = 2;
    localparam int unsigned SDP_RD_REQ_PD_W = 79;
    localparam int unsigned SDP_ARB_CDT_W   = 8;

endpackage

// File: rtl/nv_nvdla_sdp_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr, wrapping.
module nv_nvdla_sdp_arb_rr_pick
    import nv_nvdla_sdp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = SDP_ARB_NUM_REQ,
    parameter int unsigned ID_W    = SDP_ARB_ID_W
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [ID_W-1:0]    pick_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // NUM_REQ is a power of two, so the ID_W-bit sum wraps modulo NUM_REQ.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!found && elig[idx]) begin
                found            = 1'b1;
                pick_onehot[idx] = 1'b1;
                pick_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_req_arb.sv
// SDP read-request arbiter: round-robin over MRDMA/BRDMA/NRDMA/ERDMA with per-requester credits.
// Optional output-stall perf counter enabled by NVDLA_SDP_ARB_STALL_PERF_EN.
module nv_nvdla_sdp_rdma_req_arb
    import nv_nvdla_sdp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = SDP_ARB_NUM_REQ,
    parameter int unsigned PD_W     = SDP_RD_REQ_PD_W,
    parameter int unsigned CREDIT_W = SDP_ARB_CDT_W
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*PD_W-1:0] req_pd,
    input  logic [NUM_REQ-1:0]      rsp_cdt_pop,
    input  logic [CREDIT_W-1:0]     reg2dp_cdt_limit,
    input  logic                    op_load,
    output logic                    arb2if_req_valid,
    input  logic                    arb2if_req_ready,
    output logic [PD_W-1:0]         arb2if_req_pd,
    output logic [1:0]              arb2if_req_id,
    output logic                    arb_cdt_err,
    output logic [31:0]             dp2reg_arb_stall
);

    logic [CREDIT_W-1:0] outst [NUM_REQ];
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  outst_zero;
    logic [1:0]          pick_idx;
    logic [1:0]          rr_ptr;
    logic [PD_W-1:0]     sel_pd;
    logic                load;
    logic                pick_any;
    logic                pop_err;

    always_comb begin
        elig       = '0;
        outst_zero = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i]       = req_valid[i] &
                            ((reg2dp_cdt_limit == '0) | (outst[i] < reg2dp_cdt_limit));
            outst_zero[i] = (outst[i] == '0);
        end
    end

    nv_nvdla_sdp_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (2)
    ) u_rr_pick (
        .elig        (elig),
        .rr_ptr      (rr_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    always_comb begin
        load      = !arb2if_req_valid | arb2if_req_ready;
        pick_any  = |pick_onehot;
        req_ready = load ? pick_onehot : '0;
        grant     = req_ready;
        sel_pd    = req_pd[32'(pick_idx)*PD_W +: PD_W];
        // A pop that coincides with a grant nets to zero, so it never underflows.
        pop_err   = |(rsp_cdt_pop & ~grant & outst_zero);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            arb2if_req_valid <= 1'b0;
            arb2if_req_pd    <= '0;
            arb2if_req_id    <= '0;
            rr_ptr           <= '0;
        end else if (load) begin
            if (pick_any) begin
                arb2if_req_valid <= 1'b1;
                arb2if_req_pd    <= sel_pd;
                arb2if_req_id    <= pick_idx;
                rr_ptr           <= pick_idx + 2'd1;
            end else begin
                arb2if_req_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                outst[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                case ({grant[i], rsp_cdt_pop[i]})
                    2'b10: if (outst[i] != '1) outst[i] <= outst[i] + CREDIT_W'(1);
                    2'b01: if (outst[i] != '0) outst[i] <= outst[i] - CREDIT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            arb_cdt_err <= 1'b0;
        end else if (pop_err) begin
            arb_cdt_err <= 1'b1;
        end else if (op_load) begin
            arb_cdt_err <= 1'b0;
        end
    end

`ifdef NVDLA_SDP_ARB_STALL_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt <= '0;
        end else if (op_load) begin
            stall_cnt <= '0;
        end else if (arb2if_req_valid && !arb2if_req_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign dp2reg_arb_stall = stall_cnt;
`else
    assign dp2reg_arb_stall = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_req_arb.sv
// Self-checking bench for nv_nvdla_sdp_rdma_req_arb against a cycle-level behavioural model.
module tb_nv_nvdla_sdp_rdma_req_arb;

    localparam int NR   = 4;
    localparam int PDW  = 79;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*PDW-1:0] req_pd = '0;
    logic [NR-1:0]     rsp_cdt_pop = '0;
    logic [CW-1:0]     reg2dp_cdt_limit = '0;
    logic              op_load = 1'b0;
    logic              arb2if_req_valid;
    logic              arb2if_req_ready = 1'b0;
    logic [PDW-1:0]    arb2if_req_pd;
    logic [1:0]        arb2if_req_id;
    logic              arb_cdt_err;
    logic [31:0]       dp2reg_arb_stall;

    int checks = 0;
    int failures = 0;

    // reference model state
    int             m_rr;
    int             m_outst [NR];
    bit             m_valid;
    logic [PDW-1:0] m_pd;
    int             m_id;
    bit             m_err;
    longint         m_stall;

    nv_nvdla_sdp_rdma_req_arb #(
        .NUM_REQ  (NR),
        .PD_W     (PDW),
        .CREDIT_W (CW)
    ) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_pd           (req_pd),
        .rsp_cdt_pop      (rsp_cdt_pop),
        .reg2dp_cdt_limit (reg2dp_cdt_limit),
        .op_load          (op_load),
        .arb2if_req_valid (arb2if_req_valid),
        .arb2if_req_ready (arb2if_req_ready),
        .arb2if_req_pd    (arb2if_req_pd),
        .arb2if_req_id    (arb2if_req_id),
        .arb_cdt_err      (arb_cdt_err),
        .dp2reg_arb_stall (dp2reg_arb_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_rr    = 0;
        m_valid = 0;
        m_pd    = '0;
        m_id    = 0;
        m_err   = 0;
        m_stall = 0;
        for (int i = 0; i < NR; i++) m_outst[i] = 0;
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_rr + k) % NR;
            if (req_valid[i] && (reg2dp_cdt_limit == 0 || m_outst[i] < int'(reg2dp_cdt_limit)))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] model_ready();
        int  p;
        bit  ld;
        ld = !m_valid || arb2if_req_ready;
        p  = model_pick();
        if (ld && p >= 0) return NR'(1 << p);
        return '0;
    endfunction

    function automatic logic [PDW-1:0] pd_of(int i);
        return req_pd[i*PDW +: PDW];
    endfunction

    task automatic randomize_pd();
        for (int i = 0; i < NR; i++)
            req_pd[i*PDW +: PDW] = PDW'({$urandom, $urandom, $urandom});
    endtask

    // Advance one clock: update the model from the inputs seen at the edge.
    task automatic tick();
        int p;
        bit ld;
        bit g;
        ld = !m_valid || arb2if_req_ready;
        p  = model_pick();
        if (op_load) m_err = 0;
        for (int i = 0; i < NR; i++) begin
            g = ld && (p == i);
            if (g && !rsp_cdt_pop[i]) begin
                if (m_outst[i] < CMAX) m_outst[i]++;
            end else if (!g && rsp_cdt_pop[i]) begin
                if (m_outst[i] == 0) m_err = 1;
                else m_outst[i]--;
            end
        end
`ifdef NVDLA_SDP_ARB_STALL_PERF_EN
        if (op_load) m_stall = 0;
        else if (m_valid && !arb2if_req_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
        if (ld) begin
            if (p >= 0) begin
                m_valid = 1;
                m_pd    = pd_of(p);
                m_id    = p;
                m_rr    = (p + 1) % NR;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid        = '0;
        rsp_cdt_pop      = '0;
        op_load          = 1'b0;
        arb2if_req_ready = 1'b0;
        reg2dp_cdt_limit = '0;
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (arb2if_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", arb2if_req_valid); end
        checks++; if (arb2if_req_pd !== '0) begin failures++; $display("FAIL reset_pd got=%h exp=0", arb2if_req_pd); end
        checks++; if (arb2if_req_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", arb2if_req_id); end
        checks++; if (arb_cdt_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", arb_cdt_err); end
        checks++; if (dp2reg_arb_stall !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", dp2reg_arb_stall); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    endtask

    task automatic test_single_brdma();
        logic [PDW-1:0] sent;
        do_reset();
        arb2if_req_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            req_valid = 4'b0010;
            randomize_pd();
            sent = pd_of(1);
            #1;
            checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready[%0d] got=%b exp=0010", n, req_ready); end
            tick();
            checks++; if (arb2if_req_valid !== 1'b1 || arb2if_req_id !== 2'd1 || arb2if_req_pd !== sent) begin
                failures++;
                $display("FAIL single_out[%0d] got v=%0b id=%0d pd=%h exp v=1 id=1 pd=%h",
                         n, arb2if_req_valid, arb2if_req_id, arb2if_req_pd, sent);
            end
        end
        req_valid = '0;
        tick();
        checks++; if (arb2if_req_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", arb2if_req_valid); end
    endtask

    task automatic test_fairness();
        logic [PDW-1:0] exp_pd;
        do_reset();
        arb2if_req_ready = 1'b1;
        req_valid = '1;
        for (int n = 0; n < 12; n++) begin
            randomize_pd();
            exp_pd = pd_of(n % NR);
            #1;
            tick();
            checks++; if (arb2if_req_valid !== 1'b1 || int'(arb2if_req_id) != n % NR || arb2if_req_pd !== exp_pd) begin
                failures++;
                $display("FAIL fair[%0d] got v=%0b id=%0d exp v=1 id=%0d", n, arb2if_req_valid, arb2if_req_id, n % NR);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_credit_block();
        int grants;
        do_reset();
        reg2dp_cdt_limit = 8'd2;
        arb2if_req_ready = 1'b1;
        req_valid = 4'b0100;
        grants = 0;
        for (int n = 0; n < 6; n++) begin
            randomize_pd();
            #1;
            if (req_ready[2]) grants++;
            tick();
        end
        checks++; if (grants != 2) begin failures++; $display("FAIL credit_first grants=%0d exp=2", grants); end
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL credit_blocked req_ready=%b exp=0000", req_ready); end
        rsp_cdt_pop = 4'b0100;
        tick();
        rsp_cdt_pop = '0;
        grants = 0;
        for (int n = 0; n < 5; n++) begin
            #1;
            if (req_ready[2]) grants++;
            tick();
        end
        checks++; if (grants != 1) begin failures++; $display("FAIL credit_after_pop grants=%0d exp=1", grants); end
        req_valid = '0;
        reg2dp_cdt_limit = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [PDW-1:0] hold_pd;
        longint exp_stall;
        do_reset();
        arb2if_req_ready = 1'b1;
        req_valid = 4'b0001;
        randomize_pd();
        hold_pd = pd_of(0);
        #1;
        tick();
        arb2if_req_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            randomize_pd();
            req_valid = '1;
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", n, req_ready); end
            tick();
            checks++; if (arb2if_req_valid !== 1'b1 || arb2if_req_id !== 2'd0 || arb2if_req_pd !== hold_pd) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%0b id=%0d pd=%h exp v=1 id=0 pd=%h",
                         n, arb2if_req_valid, arb2if_req_id, arb2if_req_pd, hold_pd);
            end
        end
`ifdef NVDLA_SDP_ARB_STALL_PERF_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        checks++; if (longint'(dp2reg_arb_stall) != exp_stall) begin failures++; $display("FAIL bp_stall got=%0d exp=%0d", dp2reg_arb_stall, exp_stall); end
        req_valid = '0;
        arb2if_req_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_grant_pop();
        do_reset();
        arb2if_req_ready = 1'b1;
        req_valid = 4'b0001;
        randomize_pd();
        #1;
        tick();
        rsp_cdt_pop = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL gp_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        rsp_cdt_pop = '0;
        reg2dp_cdt_limit = 8'd1;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL gp_outst_is_1 req_ready=%b exp=0000", req_ready); end
        req_valid = '0;
        rsp_cdt_pop = 4'b0001;
        tick();
        rsp_cdt_pop = '0;
        checks++; if (arb_cdt_err !== 1'b0) begin failures++; $display("FAIL gp_no_err got=%0b exp=0", arb_cdt_err); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL gp_outst_is_0 req_ready=%b exp=0001", req_ready); end
        req_valid = '0;
        rsp_cdt_pop = 4'b0001;
        tick();
        rsp_cdt_pop = '0;
        checks++; if (arb_cdt_err !== 1'b1) begin failures++; $display("FAIL gp_err_set got=%0b exp=1", arb_cdt_err); end
        tick();
        checks++; if (arb_cdt_err !== 1'b1) begin failures++; $display("FAIL gp_err_sticky got=%0b exp=1", arb_cdt_err); end
        op_load = 1'b1;
        tick();
        op_load = 1'b0;
        checks++; if (arb_cdt_err !== 1'b0) begin failures++; $display("FAIL gp_err_clear got=%0b exp=0", arb_cdt_err); end
        reg2dp_cdt_limit = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0)
                reg2dp_cdt_limit = ($urandom % 4 == 0) ? 8'd0 : CW'($urandom_range(1, 3));
            req_valid = NR'($urandom);
            randomize_pd();
            for (int i = 0; i < NR; i++)
                rsp_cdt_pop[i] = (m_outst[i] > 0 && $urandom % 3 == 0) || ($urandom % 60 == 0);
            op_load = ($urandom % 25 == 0);
            arb2if_req_ready = ($urandom % 4 != 0);
            #1;
            checks++; if (req_ready !== model_ready()) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, req_ready, model_ready()); end
            tick();
            checks++; if (arb2if_req_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", n, arb2if_req_valid, m_valid); end
            if (m_valid) begin
                checks++; if (int'(arb2if_req_id) != m_id || arb2if_req_pd !== m_pd) begin
                    failures++;
                    $display("FAIL rnd_data[%0d] got id=%0d pd=%h exp id=%0d pd=%h", n, arb2if_req_id, arb2if_req_pd, m_id, m_pd);
                end
            end
            checks++; if (arb_cdt_err !== m_err) begin failures++; $display("FAIL rnd_err[%0d] got=%0b exp=%0b", n, arb_cdt_err, m_err); end
            checks++; if (longint'(dp2reg_arb_stall) != m_stall) begin failures++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", n, dp2reg_arb_stall, m_stall); end
        end
        rsp_cdt_pop = '0;
        op_load = 1'b0;
    endtask

    task automatic test_async_reset();
        arb2if_req_ready = 1'b0;
        req_valid = 4'b1000;
        randomize_pd();
        #1;
        tick();
        #2;
        rstn = 1'b0;
        req_valid = '0;
        #1;
        checks++; if (arb2if_req_valid !== 1'b0 || arb2if_req_pd !== '0 || arb2if_req_id !== 2'd0) begin
            failures++;
            $display("FAIL areset_out got v=%0b id=%0d pd=%h exp all 0", arb2if_req_valid, arb2if_req_id, arb2if_req_pd);
        end
        checks++; if (arb_cdt_err !== 1'b0 || dp2reg_arb_stall !== 32'd0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL areset_misc got err=%0b stall=%0d ready=%b exp 0", arb_cdt_err, dp2reg_arb_stall, req_ready);
        end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        arb2if_req_ready = 1'b1;
        req_valid = '1;
        randomize_pd();
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL areset_first_ready got=%b exp=0001", req_ready); end
        tick();
        checks++; if (arb2if_req_valid !== 1'b1 || arb2if_req_id !== 2'd0) begin
            failures++;
            $display("FAIL areset_first_grant got v=%0b id=%0d exp v=1 id=0", arb2if_req_valid, arb2if_req_id);
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_brdma();
        test_fairness();
        test_credit_block();
        test_backpressure();
        test_grant_pop();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
